pc_redirect_ctrl: RTL and testbench
===================================

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-003 SHALL have port IF_PC, input, 32, current PC register value.
REQ-004 SHALL have port ICache_Ready, input, 1, fetch of IF_PC accepted this cycle.
REQ-005 SHALL have port PipeStall, input, 1, ID-side stall; blocks PC advance.
REQ-006 SHALL have port Exc_Valid, input, 1, exception redirect request.
REQ-007 SHALL have port Exc_Vector, input, 32, exception target.
REQ-008 SHALL have port Eret_Valid, input, 1, ERET redirect request.
REQ-009 SHALL have port EPC, input, 32, ERET target.
REQ-010 SHALL have port Br_Taken, input, 1, taken branch/jump resolved in EX.
REQ-011 SHALL have port Br_Target, input, 32, branch target.
REQ-012 SHALL have port Br_DSFetched, input, 1, delay slot already past IF.
REQ-013 SHALL have port IF_NPC, output, 32, next PC to the PC register.
REQ-014 SHALL have port IF_PCWr, output, 1, PC register write enable.
REQ-015 SHALL have port IF_Flush, output, 1, kill the instruction leaving IF this cycle.
REQ-016 SHALL have port Redirect_Pending, output, 1, high when state != SEQ.

Function
REQ-017 SHALL define adv = ICache_Ready & ~PipeStall; IF_PCWr SHALL be 1 only when adv=1.
REQ-018 SHALL implement a three-state FSM: SEQ, WAIT_DS (target held, IF holds the delay slot), PEND (target held, IF holds a wrong-path instruction).
REQ-019 SHALL hold a 32-bit pending-target register loaded only on FSM entry to or override within WAIT_DS/PEND.
REQ-020 SHALL give redirect priority Exc_Valid > Eret_Valid > Br_Taken in every state.
REQ-021 In SEQ with no request: IF_NPC = IF_PC+4 (mod 2^32, 0xFFFFFFFC -> 0x00000000), IF_PCWr = adv, IF_Flush = 0.
REQ-022 In SEQ, on Exc/Eret: adv=1 -> IF_NPC = target, IF_PCWr=1, IF_Flush=1, stay SEQ; adv=0 -> latch target, go to PEND, IF_PCWr=0.
REQ-023 In SEQ, on Br_Taken with Br_DSFetched=1: same as REQ-022 using Br_Target.
REQ-024 In SEQ, on Br_Taken with Br_DSFetched=0: latch Br_Target and go to WAIT_DS. If adv=1, IF_NPC = IF_PC+4 is not written; IF_PCWr=0 that cycle.
REQ-025 In WAIT_DS, on adv=1: IF_NPC = pending, IF_PCWr=1, IF_Flush=0 (delay slot survives), go to SEQ.
REQ-026 In PEND, on adv=1: IF_NPC = pending, IF_PCWr=1, IF_Flush=1, go to SEQ.
REQ-027 In WAIT_DS or PEND with adv=0: IF_PCWr=0, IF_Flush=0, IF_NPC = pending.
REQ-028 In WAIT_DS or PEND, an Exc/Eret request SHALL override the pending target. With adv=1 it is written directly (Flush=1, go to SEQ); with adv=0 it is latched and the FSM goes to PEND.
REQ-029 In WAIT_DS or PEND, Br_Taken SHALL be ignored.
REQ-030 Targets SHALL pass unmodified (no alignment masking); latency from an accepted request to PC write SHALL be 0 cycles when adv=1.

Reset
REQ-031 While rst=1 (asynchronous): FSM=SEQ, pending=0x00000000, IF_PCWr=0, IF_Flush=0, Redirect_Pending=0, IF_NPC=0xBFC00000.
REQ-032 Reset asserted mid-WAIT_DS/PEND SHALL discard the pending target; after release the FSM behaves per REQ-021.

Verification
REQ-033 IF_PC=0xBFC00000, adv=1, no requests -> IF_NPC=0xBFC00004, IF_PCWr=1, IF_Flush=0; IF_PC=0xFFFFFFFC -> IF_NPC=0x00000000.
REQ-034 Br_Taken=1, Br_Target=0x80001000, Br_DSFetched=0, adv=0 for 2 cycles then 1 -> WAIT_DS, Redirect_Pending=1; on adv IF_NPC=0x80001000, IF_PCWr=1, IF_Flush=0, FSM returns to SEQ.
REQ-035 Exc_Valid=1, Exc_Vector=0xBFC00380, ICache_Ready=0 -> PEND; Br_Taken the next cycle is ignored; on adv IF_NPC=0xBFC00380, IF_Flush=1.
REQ-036 In WAIT_DS (target 0x80001000), Eret_Valid=1, EPC=0x80002000, adv=0 -> PEND with pending=0x80002000; on adv IF_NPC=0x80002000, IF_Flush=1.
REQ-037 Exc_Valid, Eret_Valid and Br_Taken all asserted with adv=1 -> IF_NPC=Exc_Vector, IF_Flush=1, FSM stays SEQ.
REQ-038 rst pulsed while in PEND -> outputs per REQ-031 immediately (no clock edge needed); first adv after release -> IF_NPC=IF_PC+4.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// Next-PC selection for the fetch stage: sequential advance, exception/ERET
// redirects and delayed-branch targets, holding a redirect until IF can accept it.
module pc_redirect_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_PC,
  input  logic        ICache_Ready,
  input  logic        PipeStall,
  input  logic        Exc_Valid,
  input  logic [31:0] Exc_Vector,
  input  logic        Eret_Valid,
  input  logic [31:0] EPC,
  input  logic        Br_Taken,
  input  logic [31:0] Br_Target,
  input  logic        Br_DSFetched,
  output logic [31:0] IF_NPC,
  output logic        IF_PCWr,
  output logic        IF_Flush,
  output logic        Redirect_Pending
);

  localparam logic [1:0] SEQ     = 2'd0;
  localparam logic [1:0] WAIT_DS = 2'd1;
  localparam logic [1:0] PEND    = 2'd2;

  localparam logic [31:0] RESET_VEC = 32'hBFC0_0000;

  logic [1:0]  state_q, state_d;
  logic [31:0] pend_q, pend_d;
  logic        adv;
  logic        hi_req;
  logic [31:0] hi_tgt;
  logic [31:0] seq_pc;
  logic [31:0] npc;
  logic        pcwr;
  logic        flush;

  assign adv    = ICache_Ready & ~PipeStall;
  assign hi_req = Exc_Valid | Eret_Valid;
  assign hi_tgt = Exc_Valid ? Exc_Vector : EPC;
  assign seq_pc = IF_PC + 32'd4;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    npc     = seq_pc;
    pcwr    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      WAIT_DS, PEND: begin
        // Branches are ignored here; only exception/ERET may replace the held target.
        npc = pend_q;
        if (hi_req) begin
          if (adv) begin
            npc     = hi_tgt;
            pcwr    = 1'b1;
            flush   = 1'b1;
            state_d = SEQ;
          end else begin
            pend_d  = hi_tgt;
            state_d = PEND;
          end
        end else if (adv) begin
          pcwr    = 1'b1;
          flush   = (state_q == PEND);
          state_d = SEQ;
        end
      end
      default: begin
        if (hi_req || (Br_Taken && Br_DSFetched)) begin
          npc = hi_req ? hi_tgt : Br_Target;
          if (adv) begin
            pcwr  = 1'b1;
            flush = 1'b1;
          end else begin
            pend_d  = npc;
            state_d = PEND;
          end
        end else if (Br_Taken) begin
          // Delay slot still to be fetched: hold the target until it leaves IF.
          pend_d  = Br_Target;
          state_d = WAIT_DS;
        end else begin
          pcwr = adv;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEQ;
      pend_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Outputs are forced while reset is asserted, without waiting for a clock edge.
  assign IF_NPC           = rst ? RESET_VEC : npc;
  assign IF_PCWr          = ~rst & pcwr;
  assign IF_Flush         = ~rst & flush;
  assign Redirect_Pending = ~rst & (state_q != SEQ);

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed vector table, reset corner
// sequence, and randomized traffic against a rule-level reference model.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IF_PC;
  logic        ICache_Ready, PipeStall;
  logic        Exc_Valid, Eret_Valid, Br_Taken, Br_DSFetched;
  logic [31:0] Exc_Vector, EPC, Br_Target;
  logic [31:0] IF_NPC;
  logic        IF_PCWr, IF_Flush, Redirect_Pending;

  int checks = 0;
  int failures = 0;

  pc_redirect_ctrl dut (
    .clk(clk), .rst(rst), .IF_PC(IF_PC), .ICache_Ready(ICache_Ready),
    .PipeStall(PipeStall), .Exc_Valid(Exc_Valid), .Exc_Vector(Exc_Vector),
    .Eret_Valid(Eret_Valid), .EPC(EPC), .Br_Taken(Br_Taken),
    .Br_Target(Br_Target), .Br_DSFetched(Br_DSFetched), .IF_NPC(IF_NPC),
    .IF_PCWr(IF_PCWr), .IF_Flush(IF_Flush), .Redirect_Pending(Redirect_Pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        rdy, stall, exc;
    logic [31:0] vec;
    logic        eret;
    logic [31:0] epc;
    logic        br;
    logic [31:0] bt;
    logic        ds;
    logic [31:0] npc;
    logic        wr, fl, rp, cn;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    IF_PC = v.pc; ICache_Ready = v.rdy; PipeStall = v.stall;
    Exc_Valid = v.exc; Exc_Vector = v.vec; Eret_Valid = v.eret; EPC = v.epc;
    Br_Taken = v.br; Br_Target = v.bt; Br_DSFetched = v.ds;
  endtask

  task automatic idle(input logic [31:0] pc, input logic rdy);
    IF_PC = pc; ICache_Ready = rdy; PipeStall = 1'b0;
    Exc_Valid = 1'b0; Exc_Vector = 32'h0; Eret_Valid = 1'b0; EPC = 32'h0;
    Br_Taken = 1'b0; Br_Target = 32'h0; Br_DSFetched = 1'b0;
  endtask

  // Reference model state: whether a redirect is held, whether the instruction
  // currently in IF is a delay slot that must survive, and the held target.
  bit          m_have;
  bit          m_keep;
  logic [31:0] m_held;

  initial begin
    vecs[0]  = '{32'hBFC00000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'hBFC00004, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{32'hFFFFFFFC, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{32'h00001000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h80001000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h00001004, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h55550000, 1'b1, 32'h80001000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{32'h00001004, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h80001000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{32'h80001000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h80001004, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{32'h80001004, 1'b0, 1'b0, 1'b1, 32'hBFC00380, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'h80001004, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h12345678, 1'b1, 32'hBFC00380, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{32'h80001004, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'hBFC00380, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{32'hBFC00380, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h80001000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'hBFC00384, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80002000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{32'hBFC00384, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h80002000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{32'hBFC00384, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h80002000, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{32'h80002000, 1'b1, 1'b0, 1'b1, 32'hBFC00380, 1'b1, 32'h80002000, 1'b1, 32'h11110000, 1'b0, 32'hBFC00380, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{32'hBFC00380, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'hBFC00384, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{32'hBFC00384, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80003000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{32'hBFC00384, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h80003000, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[17] = '{32'h80003000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h80004000, 1'b1, 32'h80004000, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[18] = '{32'h00000100, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h00000104, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state with a ready fetch on the inputs.
    rst = 1'b1;
    idle(32'h00000100, 1'b1);
    #2;
    chk("reset_npc", IF_NPC, 32'hBFC00000);
    chk("reset_pcwr", {31'b0, IF_PCWr}, 32'h0);
    chk("reset_flush", {31'b0, IF_Flush}, 32'h0);
    chk("reset_pending", {31'b0, Redirect_Pending}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      if (vecs[i].cn) chk($sformatf("vec%0d_npc", i), IF_NPC, vecs[i].npc);
      chk($sformatf("vec%0d_pcwr", i), {31'b0, IF_PCWr}, {31'b0, vecs[i].wr});
      chk($sformatf("vec%0d_flush", i), {31'b0, IF_Flush}, {31'b0, vecs[i].fl});
      chk($sformatf("vec%0d_pending", i), {31'b0, Redirect_Pending}, {31'b0, vecs[i].rp});
    end

    // Asynchronous reset while a redirect is held in PEND.
    @(negedge clk);
    idle(32'h00002000, 1'b0);
    Exc_Valid = 1'b1; Exc_Vector = 32'hBFC00380;
    @(negedge clk);
    idle(32'h00002000, 1'b1);
    PipeStall = 1'b1;
    #1;
    chk("pend_before_rst", {31'b0, Redirect_Pending}, 32'h1);
    PipeStall = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_npc", IF_NPC, 32'hBFC00000);
    chk("midrst_pcwr", {31'b0, IF_PCWr}, 32'h0);
    chk("midrst_flush", {31'b0, IF_Flush}, 32'h0);
    chk("midrst_pending", {31'b0, Redirect_Pending}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(32'h00400000, 1'b1);
    #1;
    chk("postrst_npc", IF_NPC, 32'h00400004);
    chk("postrst_pcwr", {31'b0, IF_PCWr}, 32'h1);
    chk("postrst_flush", {31'b0, IF_Flush}, 32'h0);
    chk("postrst_pending", {31'b0, Redirect_Pending}, 32'h0);

    // Randomized traffic; the model starts with nothing held, matching the DUT now.
    m_have = 1'b0; m_keep = 1'b0; m_held = 32'h0;
    for (int n = 0; n < 400; n++) begin
      logic        adv, hi;
      logic [31:0] hi_t, e_npc;
      logic        e_wr, e_fl, e_rp, c_npc;
      @(negedge clk);
      IF_PC        = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
      ICache_Ready = ($urandom_range(0, 3) != 0);
      PipeStall    = ($urandom_range(0, 3) == 0);
      Exc_Valid    = ($urandom_range(0, 7) == 0);
      Exc_Vector   = $urandom;
      Eret_Valid   = ($urandom_range(0, 7) == 0);
      EPC          = $urandom;
      Br_Taken     = ($urandom_range(0, 3) == 0);
      Br_Target    = $urandom;
      Br_DSFetched = $urandom_range(0, 1);

      adv   = ICache_Ready && !PipeStall;
      hi    = Exc_Valid || Eret_Valid;
      hi_t  = Exc_Valid ? Exc_Vector : EPC;
      e_rp  = m_have;
      e_npc = 32'h0; e_wr = 1'b0; e_fl = 1'b0; c_npc = 1'b0;
      if (!m_have) begin
        if (hi || (Br_Taken && Br_DSFetched)) begin
          if (adv) begin
            e_npc = hi ? hi_t : Br_Target; e_wr = 1'b1; e_fl = 1'b1; c_npc = 1'b1;
          end else begin
            m_have = 1'b1; m_keep = 1'b0; m_held = hi ? hi_t : Br_Target;
          end
        end else if (Br_Taken) begin
          m_have = 1'b1; m_keep = 1'b1; m_held = Br_Target;
        end else begin
          e_npc = IF_PC + 32'd4; e_wr = adv; c_npc = 1'b1;
        end
      end else begin
        if (hi) begin
          if (adv) begin
            e_npc = hi_t; e_wr = 1'b1; e_fl = 1'b1; c_npc = 1'b1; m_have = 1'b0;
          end else begin
            m_keep = 1'b0; m_held = hi_t;
          end
        end else if (adv) begin
          e_npc = m_held; e_wr = 1'b1; e_fl = !m_keep; c_npc = 1'b1; m_have = 1'b0;
        end else begin
          e_npc = m_held; c_npc = 1'b1;
        end
      end
      #1;
      if (c_npc) chk($sformatf("rnd%0d_npc", n), IF_NPC, e_npc);
      chk($sformatf("rnd%0d_pcwr", n), {31'b0, IF_PCWr}, {31'b0, e_wr});
      chk($sformatf("rnd%0d_flush", n), {31'b0, IF_Flush}, {31'b0, e_fl});
      chk($sformatf("rnd%0d_pending", n), {31'b0, Redirect_Pending}, {31'b0, e_rp});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
